// File: rtl/piso_shift_tx_pkg.sv
// Shared types and helpers for the parallel-in, serial-out shift transmitter.
// The FSM encoding and the counter width rule live here so every file agrees on them.
package piso_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  function automatic int CNT_W(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/piso_shift_tx_if.sv
// Parallel load handshake plus serial-side outputs of the shift transmitter.
// The master side offers words and watches the serial stream; the transmitter is the slave.
interface piso_shift_tx_if #(
  parameter int WIDTH = 8
);
  import piso_pkg::*;

  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] load_data;
  logic             ser_out;
  logic             ser_valid;
  logic             frame;
  logic             busy;
  logic             done;

  modport master (
    output load_valid, load_data,
    input  load_ready, ser_out, ser_valid, frame, busy, done
  );

  modport slave (
    input  load_valid, load_data,
    output load_ready, ser_out, ser_valid, frame, busy, done
  );

endinterface

// File: rtl/piso_shift_tx_dff.sv
// Single-bit D flip-flop with asynchronous active-low reset to RST_VAL.
// Every storage bit of the transmitter is built from this cell.
module dff_arn #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= RST_VAL;
    else        q <= d;
  end

endmodule

// File: rtl/piso_shift_tx.sv
// Parallel-in, serial-out transmitter: takes a word on a valid/ready handshake and
// shifts it out one bit per clock, with a frame marker on the first bit and a done pulse after the last.
module piso_shift_tx
  import piso_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b1,
  parameter bit IDLE_LVL  = 1'b0
) (
  input  logic           clk,
  input  logic           rst_n,
  piso_shift_tx_if.slave bus
);

  localparam int            CW      = CNT_W(WIDTH);
  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH - 1);

  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] sreg_d;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_d;
  logic             state_q;
  state_t           state;
  state_t           state_d;
  logic             done_q;
  logic             ready_en;
  logic             shifting;
  logic             last_bit;
  logic             xfer;

  assign state    = state_q ? ST_SHIFT : ST_IDLE;
  assign shifting = (state == ST_SHIFT);
  assign last_bit = shifting && (cnt == '0);

  // ready_en holds load_ready low through reset and releases it on the first edge afterwards.
  assign bus.load_ready = ready_en && (!shifting || last_bit);
  assign xfer           = bus.load_valid && bus.load_ready;

  // A transfer wins over shifting, so a load in the last-bit cycle restarts the word with no gap.
  always_comb begin
    sreg_d  = sreg;
    cnt_d   = cnt;
    state_d = state;
    if (xfer) begin
      sreg_d  = bus.load_data;
      cnt_d   = CNT_MAX;
      state_d = ST_SHIFT;
    end else if (shifting) begin
      sreg_d = LSB_FIRST ? (sreg >> 1) : (sreg << 1);
      if (last_bit) state_d = ST_IDLE;
      else          cnt_d   = cnt - CW'(1);
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_sreg
    dff_arn #(.RST_VAL(1'b0)) u_bit (
      .clk  (clk),
      .rst_n(rst_n),
      .d    (sreg_d[i]),
      .q    (sreg[i])
    );
  end

  for (genvar i = 0; i < CW; i++) begin : g_cnt
    dff_arn #(.RST_VAL(1'b0)) u_bit (
      .clk  (clk),
      .rst_n(rst_n),
      .d    (cnt_d[i]),
      .q    (cnt[i])
    );
  end

  dff_arn #(.RST_VAL(1'b0)) u_state (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (state_d == ST_SHIFT),
    .q    (state_q)
  );

  dff_arn #(.RST_VAL(1'b0)) u_done (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (last_bit),
    .q    (done_q)
  );

  dff_arn #(.RST_VAL(1'b0)) u_ready_en (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (1'b1),
    .q    (ready_en)
  );

  assign bus.ser_out   = shifting ? (LSB_FIRST ? sreg[0] : sreg[WIDTH-1]) : IDLE_LVL;
  assign bus.ser_valid = shifting;
  assign bus.busy      = shifting;
  assign bus.frame     = shifting && (cnt == CNT_MAX);
  assign bus.done      = done_q;

endmodule

// File: tb/tb_piso_shift_tx.sv
// Self-checking bench for piso_shift_tx: three configurations (8-bit LSB-first, 8-bit MSB-first
// with idle-high line, 2-bit) compared each cycle against a bit-index reference model.
module tb_piso_shift_tx;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  piso_shift_tx_if #(.WIDTH(8)) if_a ();
  piso_shift_tx_if #(.WIDTH(8)) if_b ();
  piso_shift_tx_if #(.WIDTH(2)) if_c ();

  piso_shift_tx #(.WIDTH(8), .LSB_FIRST(1'b1), .IDLE_LVL(1'b0)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(if_a.slave));
  piso_shift_tx #(.WIDTH(8), .LSB_FIRST(1'b0), .IDLE_LVL(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(if_b.slave));
  piso_shift_tx #(.WIDTH(2), .LSB_FIRST(1'b1), .IDLE_LVL(1'b0)) dut_c (
    .clk(clk), .rst_n(rst_n), .bus(if_c.slave));

  always #5 clk = ~clk;

  logic [5:0] obs_a, obs_b, obs_c;
  assign obs_a = {if_a.load_ready, if_a.ser_out, if_a.ser_valid, if_a.frame, if_a.busy, if_a.done};
  assign obs_b = {if_b.load_ready, if_b.ser_out, if_b.ser_valid, if_b.frame, if_b.busy, if_b.done};
  assign obs_c = {if_c.load_ready, if_c.ser_out, if_c.ser_valid, if_c.frame, if_c.busy, if_c.done};

  // Reference: the word in flight plus the index k of the bit on the wire this cycle.
  typedef struct packed {
    logic [31:0] word;
    int          k;
    int          width;
    bit          lsb;
    bit          idle;
    bit          alive;
    bit          active;
    bit          done;
  } model_t;

  model_t m_a, m_b, m_c;

  function automatic model_t model_init(input int width, input bit lsb, input bit idle);
    model_t m;
    m       = '0;
    m.width = width;
    m.lsb   = lsb;
    m.idle  = idle;
    return m;
  endfunction

  function automatic logic [5:0] model_out(input model_t m);
    logic [5:0] r;
    int         b;
    b    = m.lsb ? m.k : (m.width - 1 - m.k);
    r[5] = m.alive && (!m.active || (m.k == m.width - 1));
    r[4] = m.active ? m.word[b] : m.idle;
    r[3] = m.active;
    r[2] = m.active && (m.k == 0);
    r[1] = m.active;
    r[0] = m.done;
    return r;
  endfunction

  function automatic model_t model_step(input model_t m, input bit v, input logic [31:0] d);
    model_t n;
    bit     last;
    bit     ready;
    n       = m;
    last    = m.active && (m.k == m.width - 1);
    ready   = m.alive && (!m.active || last);
    n.alive = 1'b1;
    n.done  = last;
    if (v && ready) begin
      n.word   = d;
      n.k      = 0;
      n.active = 1'b1;
    end else if (last) begin
      n.active = 1'b0;
    end else if (m.active) begin
      n.k = m.k + 1;
    end
    return n;
  endfunction

  function automatic void reset_models();
    m_a = model_init(8, 1'b1, 1'b0);
    m_b = model_init(8, 1'b0, 1'b1);
    m_c = model_init(2, 1'b1, 1'b0);
  endfunction

  // Drive at the falling edge, let one rising edge pass, return at the next falling edge.
  task automatic tick(input bit va, input logic [31:0] da, input bit vb, input logic [31:0] db,
                      input bit vc, input logic [31:0] dc);
    if_a.load_valid = va;
    if_a.load_data  = da[7:0];
    if_b.load_valid = vb;
    if_b.load_data  = db[7:0];
    if_c.load_valid = vc;
    if_c.load_data  = dc[1:0];
    @(posedge clk);
    if (rst_n) begin
      m_a = model_step(m_a, va, da);
      m_b = model_step(m_b, vb, db);
      m_c = model_step(m_c, vc, dc);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    reset_models();
    tick(0, $urandom, 0, $urandom, 0, $urandom);
    tick(0, $urandom, 0, $urandom, 0, $urandom);
    total += 3;
    if (obs_a !== 6'b000000) begin bad++; $display("[TB] FAIL reset_a got=%b want=%b", obs_a, 6'b000000); end
    if (obs_b !== 6'b010000) begin bad++; $display("[TB] FAIL reset_b got=%b want=%b", obs_b, 6'b010000); end
    if (obs_c !== 6'b000000) begin bad++; $display("[TB] FAIL reset_c got=%b want=%b", obs_c, 6'b000000); end
    rst_n = 1'b1;
    #1;
    total++;
    if (obs_a !== 6'b000000) begin bad++; $display("[TB] FAIL release_no_ready got=%b want=%b", obs_a, 6'b000000); end
    @(negedge clk);
    tick(0, 0, 0, 0, 0, 0);
    total += 2;
    if (obs_a !== 6'b100000) begin bad++; $display("[TB] FAIL ready_after_edge_a got=%b want=%b", obs_a, 6'b100000); end
    if (obs_b !== 6'b110000) begin bad++; $display("[TB] FAIL ready_after_edge_b got=%b want=%b", obs_b, 6'b110000); end
  endtask

  task automatic test_single_word();
    logic [5:0] exp;
    logic [7:0] got;
    int         n;
    int         done_cyc;
    got      = '0;
    n        = 0;
    done_cyc = -1;
    tick(1, 32'hA5, 0, 0, 0, 0);
    for (int c = 1; c <= 11; c++) begin
      exp = model_out(m_a);
      total++;
      if (obs_a !== exp) begin bad++; $display("[TB] FAIL single_word cyc=%0d got=%b want=%b", c, obs_a, exp); end
      if (if_a.ser_valid === 1'b1 && n < 8) begin got[n] = if_a.ser_out; n++; end
      if (if_a.done === 1'b1) done_cyc = c;
      tick(0, 0, 0, 0, 0, 0);
    end
    total += 2;
    if (got !== 8'hA5 || n != 8) begin bad++; $display("[TB] FAIL single_word_bits got=%h/%0d want=a5/8", got, n); end
    if (done_cyc != 9) begin bad++; $display("[TB] FAIL single_word_done got=%0d want=9", done_cyc); end
  endtask

  task automatic test_msb_first();
    logic [5:0] exp;
    logic [7:0] got;
    int         busy_cnt;
    got      = '0;
    busy_cnt = 0;
    tick(0, 0, 1, 32'hC3, 0, 0);
    for (int c = 1; c <= 11; c++) begin
      exp = model_out(m_b);
      total++;
      if (obs_b !== exp) begin bad++; $display("[TB] FAIL msb_first cyc=%0d got=%b want=%b", c, obs_b, exp); end
      if (if_b.busy === 1'b1) begin busy_cnt++; got = {got[6:0], if_b.ser_out}; end
      tick(0, 0, 0, 0, 0, 0);
    end
    total += 2;
    if (got !== 8'hC3) begin bad++; $display("[TB] FAIL msb_first_bits got=%h want=c3", got); end
    if (busy_cnt != 8) begin bad++; $display("[TB] FAIL msb_first_busy got=%0d want=8", busy_cnt); end
  endtask

  task automatic test_back_to_back();
    logic [5:0]  exp;
    logic [7:0]  words [2];
    int          idx;
    int          sv_cnt;
    logic [31:0] frame_mask;
    logic [31:0] done_mask;
    words[0]   = 8'hFF;
    words[1]   = 8'h00;
    idx        = 0;
    sv_cnt     = 0;
    frame_mask = '0;
    done_mask  = '0;
    for (int c = 0; c <= 20; c++) begin
      exp = model_out(m_a);
      total++;
      if (obs_a !== exp) begin bad++; $display("[TB] FAIL back_to_back cyc=%0d got=%b want=%b", c, obs_a, exp); end
      if (if_a.ser_valid === 1'b1) sv_cnt++;
      if (if_a.frame === 1'b1) frame_mask[c] = 1'b1;
      if (if_a.done === 1'b1) done_mask[c] = 1'b1;
      if (idx < 2) begin
        tick(1, {24'h0, words[idx]}, 0, 0, 0, 0);
        if (exp[5]) idx++;
      end else begin
        tick(0, 0, 0, 0, 0, 0);
      end
    end
    total += 3;
    if (sv_cnt != 16) begin bad++; $display("[TB] FAIL b2b_valid_len got=%0d want=16", sv_cnt); end
    if (frame_mask !== 32'h0000_0202) begin bad++; $display("[TB] FAIL b2b_frames got=%h want=00000202", frame_mask); end
    if (done_mask !== 32'h0002_0200) begin bad++; $display("[TB] FAIL b2b_dones got=%h want=00020200", done_mask); end
  endtask

  task automatic test_load_while_busy();
    logic [5:0] exp;
    logic [7:0] got;
    int         n;
    int         acc_cyc;
    bit         pend;
    got     = '0;
    n       = 0;
    acc_cyc = -1;
    pend    = 1'b0;
    tick(1, 32'hA5, 0, 0, 0, 0);
    for (int c = 1; c <= 19; c++) begin
      exp = model_out(m_a);
      total++;
      if (obs_a !== exp) begin bad++; $display("[TB] FAIL load_busy cyc=%0d got=%b want=%b", c, obs_a, exp); end
      if (c >= 9 && if_a.ser_valid === 1'b1 && n < 8) begin got[n] = if_a.ser_out; n++; end
      if (c == 3) pend = 1'b1;
      if (pend && exp[5]) acc_cyc = c;
      tick(pend, 32'h5A, 0, 0, 0, 0);
      if (pend && exp[5]) pend = 1'b0;
    end
    total += 2;
    if (acc_cyc != 8) begin bad++; $display("[TB] FAIL load_busy_accept got=%0d want=8", acc_cyc); end
    if (got !== 8'h5A || n != 8) begin bad++; $display("[TB] FAIL load_busy_word got=%h/%0d want=5a/8", got, n); end
  endtask

  task automatic test_reset_mid();
    logic [5:0] exp;
    logic [7:0] got;
    int         n;
    got = '0;
    n   = 0;
    tick(1, 32'hA5, 0, 0, 0, 0);
    for (int c = 1; c <= 4; c++) begin
      exp = model_out(m_a);
      total++;
      if (obs_a !== exp) begin bad++; $display("[TB] FAIL pre_abort cyc=%0d got=%b want=%b", c, obs_a, exp); end
      if (c < 4) tick(0, 0, 0, 0, 0, 0);
    end
    #2 rst_n = 1'b0;
    #1;
    reset_models();
    total += 2;
    if (obs_a !== 6'b000000) begin bad++; $display("[TB] FAIL abort_async_a got=%b want=%b", obs_a, 6'b000000); end
    if (obs_b !== 6'b010000) begin bad++; $display("[TB] FAIL abort_async_b got=%b want=%b", obs_b, 6'b010000); end
    for (int c = 0; c < 2; c++) begin
      tick(0, 0, 0, 0, 0, 0);
      total++;
      if (obs_a !== 6'b000000) begin bad++; $display("[TB] FAIL abort_hold cyc=%0d got=%b want=%b", c, obs_a, 6'b000000); end
    end
    rst_n = 1'b1;
    for (int c = 0; c < 2; c++) begin
      exp = model_out(m_a);
      total++;
      if (obs_a !== exp) begin bad++; $display("[TB] FAIL post_abort cyc=%0d got=%b want=%b", c, obs_a, exp); end
      tick(c == 1, 32'h81, 0, 0, 0, 0);
    end
    for (int c = 1; c <= 10; c++) begin
      exp = model_out(m_a);
      total++;
      if (obs_a !== exp) begin bad++; $display("[TB] FAIL fresh_word cyc=%0d got=%b want=%b", c, obs_a, exp); end
      if (if_a.ser_valid === 1'b1 && n < 8) begin got[n] = if_a.ser_out; n++; end
      tick(0, 0, 0, 0, 0, 0);
    end
    total++;
    if (got !== 8'h81 || n != 8) begin bad++; $display("[TB] FAIL fresh_word_bits got=%h/%0d want=81/8", got, n); end
  endtask

  task automatic test_boundary_width();
    logic [5:0] exp;
    logic [1:0] got;
    int         n;
    int         done_cyc;
    got      = '0;
    n        = 0;
    done_cyc = -1;
    tick(0, 0, 0, 0, 1, 32'h2);
    for (int c = 1; c <= 16; c++) begin
      exp = model_out(m_c);
      total += 2;
      if (obs_c !== exp) begin bad++; $display("[TB] FAIL width2 cyc=%0d got=%b want=%b", c, obs_c, exp); end
      if (dut_c.cnt > 1'b1) begin bad++; $display("[TB] FAIL width2_cnt cyc=%0d got=%0d want<=1", c, dut_c.cnt); end
      if (c <= 2 && if_c.ser_valid === 1'b1) begin got[n] = if_c.ser_out; n++; end
      if (c <= 4 && if_c.done === 1'b1 && done_cyc < 0) done_cyc = c;
      tick(0, 0, 0, 0, c >= 5 && c <= 12, $urandom);
    end
    total += 2;
    if (got !== 2'b10 || n != 2) begin bad++; $display("[TB] FAIL width2_bits got=%b/%0d want=10/2", got, n); end
    if (done_cyc != 3) begin bad++; $display("[TB] FAIL width2_done got=%0d want=3", done_cyc); end
  endtask

  task automatic test_random();
    logic [5:0]  ea, eb, ec;
    bit          pv [3];
    logic [31:0] pd [3];
    for (int i = 0; i < 3; i++) begin pv[i] = 1'b0; pd[i] = '0; end
    for (int c = 0; c < 400; c++) begin
      ea = model_out(m_a);
      eb = model_out(m_b);
      ec = model_out(m_c);
      total += 3;
      if (obs_a !== ea) begin bad++; $display("[TB] FAIL random_a cyc=%0d got=%b want=%b", c, obs_a, ea); end
      if (obs_b !== eb) begin bad++; $display("[TB] FAIL random_b cyc=%0d got=%b want=%b", c, obs_b, eb); end
      if (obs_c !== ec) begin bad++; $display("[TB] FAIL random_c cyc=%0d got=%b want=%b", c, obs_c, ec); end
      for (int i = 0; i < 3; i++) begin
        if (!pv[i] && $urandom_range(0, 3) != 0) begin pv[i] = 1'b1; pd[i] = $urandom; end
      end
      tick(pv[0], pd[0], pv[1], pd[1], pv[2], pd[2]);
      if (pv[0] && ea[5]) pv[0] = 1'b0;
      if (pv[1] && eb[5]) pv[1] = 1'b0;
      if (pv[2] && ec[5]) pv[2] = 1'b0;
    end
    for (int c = 0; c < 10; c++) tick(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst_n           = 1'b0;
    if_a.load_valid = 1'b0;
    if_a.load_data  = '0;
    if_b.load_valid = 1'b0;
    if_b.load_data  = '0;
    if_c.load_valid = 1'b0;
    if_c.load_data  = '0;
    @(negedge clk);
    test_reset();
    test_single_word();
    test_msb_first();
    test_back_to_back();
    test_load_while_busy();
    test_reset_mid();
    test_boundary_width();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/piso_shift_tx.md
Name: piso_shift_tx

Overview:
Parallel-in, serial-out shift transmitter built around a WIDTH-bit register of reset-able D flip-flops. It is the driving end of the serial bit link whose receiving end captures the stream into flip-flops.
- Accepts a parallel word through a valid/ready handshake.
- Shifts the word out one bit per clock, with a frame marker on the first bit and a done pulse after the last bit.
- Sits between parallel datapath logic and a single-wire serial output.

Parameters:
- WIDTH, 8, word length in bits; legal range 2..32.
- LSB_FIRST, 1, 1 = bit 0 transmitted first; 0 = bit WIDTH-1 transmitted first.
- IDLE_LVL, 0, level driven on ser_out when no bit is being transmitted.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- load_valid  input  1  parallel word offered.
- load_ready  output  1  transmitter can accept a word this cycle.
- load_data  input  WIDTH  word to transmit; sampled only on handshake.
- ser_out  output  1  serial data bit.
- ser_valid  output  1  ser_out carries a data bit this cycle.
- frame  output  1  high with the first bit of each word.
- busy  output  1  word in flight.
- done  output  1  one-cycle pulse in the cycle after the last bit.

Behaviour:
- Reset (async assert, sync release): state=IDLE, shift register=0, bit counter=0.
  - Outputs during reset: load_ready=0, ser_out=IDLE_LVL, ser_valid=0, frame=0, busy=0, done=0.
  - load_ready rises in the first clock edge after rst_n deasserts.
- States:
  - IDLE: load_ready=1, busy=0, ser_valid=0, ser_out=IDLE_LVL.
  - SHIFT: busy=1, ser_valid=1.
- Handshake: a transfer occurs on a rising edge with load_valid && load_ready.
  - On transfer: load_data is copied into the shift register, counter=WIDTH-1, state goes to SHIFT.
  - load_data is ignored when no transfer occurs.
- Latency: first bit appears on ser_out in the cycle immediately after the handshake edge (1 cycle). A word occupies exactly WIDTH cycles of ser_valid.
- Bit order:
  - ser_out is combinational from the register end: bit 0 when LSB_FIRST=1, bit WIDTH-1 otherwise.
  - Each SHIFT cycle the register shifts toward the output end, zero-filling.
- frame=1 only in the first SHIFT cycle of each word (counter==WIDTH-1).
- Counter decrements every SHIFT cycle. The counter==0 cycle is the last-bit cycle.
- load_ready in SHIFT: high only in the last-bit cycle, which allows back-to-back streaming.
  - Transfer in the last-bit cycle: reload the register, counter=WIDTH-1, stay in SHIFT. The next cycle has frame=1 with no idle gap.
  - No transfer in the last-bit cycle: go to IDLE.
- done: registered, high in the cycle after every last-bit cycle. This holds for both the reload and return-to-IDLE cases, so done can coincide with frame of the next word.
- load_valid while busy and not in the last-bit cycle: load_ready=0, no transfer, word stays pending upstream. The transmitter does not drop or overwrite it.
- Reset mid-word: immediate abort; the partial word is discarded, no done pulse is emitted, and outputs return to reset values.
- Counter width: $clog2(WIDTH). Arithmetic is unsigned, with no wrap because decrement stops at 0.

Decomposition:
- Shared package piso_pkg:
  - state enum {ST_IDLE, ST_SHIFT}.
  - CNT_W function ($clog2).
- One sub-module, dff_arn (single-bit D flip-flop with asynchronous active-low reset to a parameter RST_VAL).
  - Used for the WIDTH register bits, the counter bits, the state bit and the done flop.
  - Keeps the structural flip-flop style of the logic-circuits series.

Test Plan:
- Reset then single word: WIDTH=8, LSB_FIRST=1, load 8'hA5 at cycle 0 -> ser_out 1,0,1,0,0,1,0,1 on cycles 1..8 with ser_valid=1, frame=1 only at cycle 1, done=1 at cycle 9, then IDLE with ser_out=IDLE_LVL.
- MSB-first: LSB_FIRST=0, load 8'hC3 -> 1,1,0,0,0,0,1,1; busy high for exactly 8 cycles.
- Back-to-back: load_valid held high with 8'hFF then 8'h00 -> second handshake in the last-bit cycle (cycle 8), ser_valid continuous for 16 cycles, frame at cycles 1 and 9, done at cycles 9 and 17.
- Load while busy: assert load_valid with 8'h5A at cycle 3 of an 8'hA5 word -> load_ready=0 until cycle 8; 8'h5A accepted at cycle 8 and emitted intact starting at cycle 9.
- Reset mid-word: drop rst_n at cycle 4 for 2 cycles -> outputs go to reset values asynchronously, no done pulse; a fresh load of 8'h81 afterwards transmits correctly.
- Boundary width: WIDTH=2, load 2'b10 -> 0,1 then done; counter never underflows (assertion: counter ≤ WIDTH-1 always).
